// File: rtl/chi_slave_mem_ctrl.sv
// Memory-backed CHI slave: in-order request FIFO, local byte-enabled memory, registered responses.
// Optional per-type response counters are enabled with `define CHI_SLV_PERF_CNT_EN.
module chi_slave_mem_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_opcode,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [ID_W-1:0]     req_txnid,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_txnid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp
`ifdef CHI_SLV_PERF_CNT_EN
  ,
  output logic [15:0]         rd_cnt,
  output logic [15:0]         wr_cnt,
  output logic [15:0]         err_cnt
`endif
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned PTR_W = $clog2(REQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [3:0] OP_RD       = 4'b0001;
  localparam logic [3:0] OP_WR       = 4'b0010;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [3:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  req_t              fifo_q [REQ_DEPTH];
  logic [DATA_W-1:0] mem_q  [MEM_DEPTH];

  state_t            state_q;
  req_t              cur_q;
  logic [LAT_W-1:0]  cnt_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_txnid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [1:0]        rsp_resp_q;

  logic              empty_c, full_c, push_c, pop_c, hs_c, exec_c;
  logic              ill_c, dec_c, wr_en_c;
  logic [ADDR_W-1:0] widx_c;
  logic [IDX_W-1:0]  idx_c;

  // Ready is withheld while reset is held; a same-cycle pop never raises it.
  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_W'(REQ_DEPTH));
  assign req_ready = ~reset & ~full_c;
  assign push_c  = req_valid & req_ready;
  assign hs_c    = (state_q == S_RESP) & rsp_ready;
  assign pop_c   = ~empty_c & ((state_q == S_IDLE) | hs_c);
  assign exec_c  = (state_q == S_ACCESS) & (cnt_q == '0);

  // Decode of the request in service; illegal opcode outranks an out-of-range address.
  assign widx_c  = cur_q.addr >> OFF_W;
  assign idx_c   = widx_c[IDX_W-1:0];
  assign ill_c   = (cur_q.op != OP_RD) && (cur_q.op != OP_WR);
  assign dec_c   = (widx_c >= ADDR_W'(MEM_DEPTH));
  assign wr_en_c = exec_c & ~ill_c & ~dec_c & (cur_q.op == OP_WR);

  assign rsp_valid = rsp_valid_q;
  assign rsp_txnid = rsp_txnid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  // FIFO bookkeeping, service FSM and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_txnid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        cur_q    <= fifo_q[rd_ptr_q];
        cnt_q    <= LAT_W'(RD_LAT - 1);
      end
      if (push_c && !pop_c)      count_q <= count_q + CNT_W'(1);
      else if (!push_c && pop_c) count_q <= count_q - CNT_W'(1);

      case (state_q)
        S_IDLE: begin
          if (pop_c) state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - LAT_W'(1);
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_txnid_q <= cur_q.id;
            state_q     <= S_RESP;
            if (ill_c) begin
              rsp_resp_q  <= RESP_SLVERR;
              rsp_rdata_q <= '0;
            end else if (dec_c) begin
              rsp_resp_q  <= RESP_DECERR;
              rsp_rdata_q <= '0;
            end else begin
              rsp_resp_q  <= RESP_OKAY;
              rsp_rdata_q <= (cur_q.op == OP_RD) ? mem_q[idx_c] : '0;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= pop_c ? S_ACCESS : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset: memory contents survive a reset.
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= '{op: req_opcode, addr: req_addr, id: req_txnid,
                                      wdata: req_wdata, be: req_be};
    if (wr_en_c) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (cur_q.be[i]) mem_q[idx_c][8*i +: 8] <= cur_q.wdata[8*i +: 8];
      end
    end
  end

`ifdef CHI_SLV_PERF_CNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  // Saturating counters bumped on each response handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (hs_c) begin
      if (rsp_resp_q != RESP_OKAY) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (cur_q.op == OP_RD) begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end else begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_chi_slave_mem_ctrl.sv
// Directed bench for chi_slave_mem_ctrl: one RD_LAT=1 instance and one RD_LAT=3 instance.
module tb_chi_slave_mem_ctrl;

  localparam logic [3:0] OP_RD = 4'b0001;
  localparam logic [3:0] OP_WR = 4'b0010;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid3, req_ready, req_ready3;
  logic [3:0]  req_opcode;
  logic [31:0] req_addr;
  logic [3:0]  req_txnid;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_valid3, rsp_ready, rsp_ready3;
  logic [3:0]  rsp_txnid, rsp_txnid3;
  logic [31:0] rsp_rdata, rsp_rdata3;
  logic [1:0]  rsp_resp, rsp_resp3;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0;

`ifdef CHI_SLV_PERF_CNT_EN
  logic [15:0] rd_cnt, wr_cnt, err_cnt, rd_cnt3, wr_cnt3, err_cnt3;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chi_slave_mem_ctrl #(.RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_txnid(req_txnid), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_txnid(rsp_txnid),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp)
`ifdef CHI_SLV_PERF_CNT_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err_cnt(err_cnt)
`endif
  );

  chi_slave_mem_ctrl #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_txnid(req_txnid), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_txnid(rsp_txnid3),
    .rsp_rdata(rsp_rdata3), .rsp_resp(rsp_resp3)
`ifdef CHI_SLV_PERF_CNT_EN
    , .rd_cnt(rd_cnt3), .wr_cnt(wr_cnt3), .err_cnt(err_cnt3)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request and hold it until the accepting edge.
  task automatic send(input bit l3, input string tag, input logic [3:0] op,
                      input logic [31:0] addr, input logic [3:0] id,
                      input logic [31:0] wd, input logic [3:0] be);
    req_opcode = op; req_addr = addr; req_txnid = id; req_wdata = wd; req_be = be;
    if (l3) req_valid3 = 1'b1; else req_valid = 1'b1;
    for (int i = 0; i < 40 && !(l3 ? req_ready3 : req_ready); i++) step();
    chk({tag, "_accept"}, l3 ? req_ready3 : req_ready, 1);
    step();
    req_valid = 1'b0;
    req_valid3 = 1'b0;
  endtask

  // Wait for a response, check it, then complete the handshake.
  task automatic get_rsp(input bit l3, input string tag, input logic [3:0] id,
                         input logic [31:0] rd, input logic [1:0] rs);
    for (int i = 0; i < 60 && !(l3 ? rsp_valid3 : rsp_valid); i++) step();
    chk({tag, "_valid"}, l3 ? rsp_valid3 : rsp_valid, 1);
    chk({tag, "_id"},    l3 ? rsp_txnid3 : rsp_txnid, id);
    chk({tag, "_rdata"}, l3 ? rsp_rdata3 : rsp_rdata, rd);
    chk({tag, "_resp"},  l3 ? rsp_resp3 : rsp_resp, rs);
    if (l3) rsp_ready3 = 1'b1; else rsp_ready = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_valid3 = 0; rsp_ready = 0; rsp_ready3 = 0;
    req_opcode = 0; req_addr = 0; req_txnid = 0; req_wdata = 0; req_be = 0;
    repeat (2) step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_txnid", rsp_txnid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", rsp_resp, 0);
    chk("rst_req_ready3", req_ready3, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_req_ready", req_ready, 1);
    step();

    // 1: write then read, first response RD_LAT+1 cycles after accept
    rsp_ready = 1'b1;
    send(0, "t1_wr", OP_WR, 32'h10, 4'd3, 32'hDEADBEEF, 4'hF);
    chk("t1_lat0", rsp_valid, 0);
    step();
    chk("t1_lat1", rsp_valid, 0);
    step();
    chk("t1_lat2", rsp_valid, 1);
    get_rsp(0, "t1_wr", 4'd3, 32'h0, OKAY);
    send(0, "t1_rd", OP_RD, 32'h10, 4'd5, 32'h0, 4'h0);
    get_rsp(0, "t1_rd", 4'd5, 32'hDEADBEEF, OKAY);

    // 2: partial byte-enable write
    send(0, "t2_wr", OP_WR, 32'h10, 4'd1, 32'h11223344, 4'b0101);
    get_rsp(0, "t2_wr", 4'd1, 32'h0, OKAY);
    send(0, "t2_rd", OP_RD, 32'h10, 4'd2, 32'h0, 4'h0);
    get_rsp(0, "t2_rd", 4'd2, 32'hDE22BE44, OKAY);

    // 3: errors, boundary word, ignored low bits, empty byte enable
    send(0, "t3_dec", OP_RD, 32'h400, 4'd4, 32'h0, 4'h0);
    get_rsp(0, "t3_dec", 4'd4, 32'h0, DECERR);
    send(0, "t3_wlast", OP_WR, 32'h3FC, 4'd6, 32'hCAFEF00D, 4'hF);
    get_rsp(0, "t3_wlast", 4'd6, 32'h0, OKAY);
    send(0, "t3_rlast", OP_RD, 32'h3FF, 4'd7, 32'h0, 4'h0);
    get_rsp(0, "t3_rlast", 4'd7, 32'hCAFEF00D, OKAY);
    send(0, "t3_ill", 4'b0111, 32'h10, 4'd8, 32'hFFFFFFFF, 4'hF);
    get_rsp(0, "t3_ill", 4'd8, 32'h0, SLVERR);
    send(0, "t3_illdec", 4'b0000, 32'h400, 4'd12, 32'h0, 4'hF);
    get_rsp(0, "t3_illdec", 4'd12, 32'h0, SLVERR);
    send(0, "t3_wdec", OP_WR, 32'h400, 4'd9, 32'hFFFFFFFF, 4'hF);
    get_rsp(0, "t3_wdec", 4'd9, 32'h0, DECERR);
    send(0, "t3_be0", OP_WR, 32'h10, 4'd10, 32'h0, 4'h0);
    get_rsp(0, "t3_be0", 4'd10, 32'h0, OKAY);
    send(0, "t3_rd", OP_RD, 32'h12, 4'd11, 32'h0, 4'h0);
    get_rsp(0, "t3_rd", 4'd11, 32'hDE22BE44, OKAY);

    // 4: stalled response channel fills 4 FIFO entries plus 1 in service
    rsp_ready = 1'b0;
    send(0, "t4_k0", OP_WR, 32'h20, 4'd8, 32'h01010101, 4'hF);
    send(0, "t4_k1", OP_WR, 32'h24, 4'd9, 32'h02020202, 4'hF);
    send(0, "t4_k2", OP_WR, 32'h28, 4'd10, 32'h03030303, 4'hF);
    send(0, "t4_k3", OP_RD, 32'h20, 4'd11, 32'h0, 4'h0);
    send(0, "t4_k4", OP_RD, 32'h24, 4'd12, 32'h0, 4'h0);
    chk("t4_full", req_ready, 0);
    req_opcode = OP_RD; req_addr = 32'h28; req_txnid = 4'd13; req_valid = 1'b1;
    repeat (3) step();
    chk("t4_still_full", req_ready, 0);
    chk("t4_hold_valid", rsp_valid, 1);
    chk("t4_hold_id", rsp_txnid, 8);
    rsp_ready = 1'b1;
    get_rsp(0, "t4_r0", 4'd8, 32'h0, OKAY);
    chk("t4_space", req_ready, 1);
    step();
    req_valid = 1'b0;
    get_rsp(0, "t4_r1", 4'd9, 32'h0, OKAY);
    get_rsp(0, "t4_r2", 4'd10, 32'h0, OKAY);
    get_rsp(0, "t4_r3", 4'd11, 32'h01010101, OKAY);
    get_rsp(0, "t4_r4", 4'd12, 32'h02020202, OKAY);
    get_rsp(0, "t4_r5", 4'd13, 32'h03030303, OKAY);
    chk("t4_drained", rsp_valid, 0);

    // 5: RD_LAT=3, back-to-back reads, one response every 4 cycles
    rsp_ready3 = 1'b1;
    send(1, "t5_wr", OP_WR, 32'h0, 4'd1, 32'hA5A5A5A5, 4'hF);
    get_rsp(1, "t5_wr", 4'd1, 32'h0, OKAY);
    req_opcode = OP_RD; req_addr = 32'h0; req_txnid = 4'd2; req_valid3 = 1'b1;
    step();
    t0 = cyc;
    req_txnid = 4'd3;
    step();
    req_txnid = 4'd4;
    step();
    req_valid3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 30 && !rsp_valid3; i++) step();
      chk("t5_lat", 64'(cyc - t0), 64'(4 * (k + 1)));
      chk("t5_id", rsp_txnid3, 64'(k + 2));
      chk("t5_rdata", rsp_rdata3, 32'hA5A5A5A5);
      step();
    end

    // 6: reset while in RESP with 2 queued entries
    rsp_ready = 1'b0;
    send(0, "t6_a", OP_RD, 32'h10, 4'd1, 32'h0, 4'h0);
    send(0, "t6_b", OP_RD, 32'h10, 4'd2, 32'h0, 4'h0);
    send(0, "t6_c", OP_RD, 32'h10, 4'd3, 32'h0, 4'h0);
    chk("t6_in_resp", rsp_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", rsp_valid, 0);
    chk("t6_rst_ready", req_ready, 0);
    #2 reset = 1'b0;
    #1;
    chk("t6_rel_ready", req_ready, 1);
    chk("t6_rel_txnid", rsp_txnid, 0);
    rsp_ready = 1'b1;
    repeat (4) step();
    chk("t6_flushed", rsp_valid, 0);
    send(0, "t6_rd", OP_RD, 32'h10, 4'd6, 32'h0, 4'h0);
    get_rsp(0, "t6_rd", 4'd6, 32'hDE22BE44, OKAY);
    send(0, "t6_rd2", OP_RD, 32'h20, 4'd7, 32'h0, 4'h0);
    get_rsp(0, "t6_rd2", 4'd7, 32'h01010101, OKAY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
